schnorr_resp: RTL and testbench

SCHNORR_RESP -- requirements
Module: schnorr_resp

---
 rtl/schnorr_resp_if.sv | 25 ++
 rtl/schnorr_resp.sv | 142 ++++++++++++++
 tb/tb_schnorr_resp.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/schnorr_resp_if.sv
// Handshake/data bundle for the Schnorr response unit: key load, request, and result channels.
interface schnorr_resp_if #(
    parameter int len = 32
);
    logic           key_valid;
    logic [len-1:0] priv_key;
    logic           start;
    logic [len-1:0] k_in;
    logic [len-1:0] e_in;
    logic           ready;
    logic [len-1:0] s_out;
    logic           s_valid;
    logic           s_ready;
    logic           busy;

    modport slave (
        input  key_valid, priv_key, start, k_in, e_in, s_ready,
        output ready, s_out, s_valid, busy
    );

    modport master (
        output key_valid, priv_key, start, k_in, e_in, s_ready,
        input  ready, s_out, s_valid, busy
    );
endinterface

// File: rtl/schnorr_resp.sv
// Schnorr response s = (k + x*e) mod q via bit-serial reduction and interleaved multiply.
// Optional macro SCHNORR_ZEROIZE_EN wipes the key on every result handoff.
module schnorr_resp #(
    parameter int             len = 32,
    parameter logic [len-1:0] q   = 32'hFFFFFFFB
) (
    input  logic              clk,
    input  logic              rst_n,
    schnorr_resp_if.slave     bus
);
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RED  = 3'd1,
        MUL  = 3'd2,
        ADD  = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam int             CW       = $clog2(len + 1);
    localparam logic [len:0]   QX       = {1'b0, q};
    localparam logic [CW-1:0]  LAST_RED = CW'(len);
    localparam logic [CW-1:0]  LAST_MUL = CW'(len - 1);

    state_t         r_state, w_state_next;
    logic [CW-1:0]  r_cnt;
    logic [len-1:0] r_key;
    logic           r_key_loaded;
    logic [len-1:0] r_xsh, r_ksh, r_esh;
    logic [len-1:0] r_xr, r_kr, r_a;
    logic [len-1:0] r_s_out;
    logic           r_s_valid;

    logic           w_accept;
    logic [len-1:0] w_a_dbl, w_a_mul;

    // 2r + b for r < q stays below 2q, so one conditional subtract suffices.
    function automatic logic [len-1:0] mod_dbl(input logic [len-1:0] r, input logic b);
        logic [len:0] t;
        logic [len:0] d;
        t = {r, b};
        d = t - QX;
        return (t >= QX) ? d[len-1:0] : t[len-1:0];
    endfunction

    function automatic logic [len-1:0] mod_add(input logic [len-1:0] a, input logic [len-1:0] b);
        logic [len:0] t;
        logic [len:0] d;
        t = {1'b0, a} + {1'b0, b};
        d = t - QX;
        return (t >= QX) ? d[len-1:0] : t[len-1:0];
    endfunction

    assign w_accept = (r_state == IDLE) && r_key_loaded && bus.start;
    assign w_a_dbl  = mod_dbl(r_a, 1'b0);
    assign w_a_mul  = r_esh[len-1] ? mod_add(w_a_dbl, r_xr) : w_a_dbl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_next = RED;
            RED:     if (r_cnt == LAST_RED) w_state_next = MUL;
            MUL:     if (r_cnt == LAST_MUL) w_state_next = ADD;
            ADD:     w_state_next = DONE;
            DONE:    if (bus.s_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_key        <= '0;
            r_key_loaded <= 1'b0;
            r_xsh        <= '0;
            r_ksh        <= '0;
            r_esh        <= '0;
            r_xr         <= '0;
            r_kr         <= '0;
            r_a          <= '0;
            r_s_out      <= '0;
            r_s_valid    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.key_valid) begin
                        r_key        <= bus.priv_key;
                        r_key_loaded <= 1'b1;
                    end
                    if (w_accept) begin
                        r_ksh <= bus.k_in;
                        r_esh <= bus.e_in;
                        r_cnt <= '0;
                    end
                end
                RED: begin
                    r_cnt <= (r_cnt == LAST_RED) ? '0 : r_cnt + 1'b1;
                    // First RED cycle snapshots the key, so a key written on the accept edge is used.
                    if (r_cnt == '0) begin
                        r_xsh <= r_key;
                        r_xr  <= '0;
                        r_kr  <= '0;
                        r_a   <= '0;
                    end else begin
                        r_xr  <= mod_dbl(r_xr, r_xsh[len-1]);
                        r_kr  <= mod_dbl(r_kr, r_ksh[len-1]);
                        r_xsh <= r_xsh << 1;
                        r_ksh <= r_ksh << 1;
                    end
                end
                MUL: begin
                    r_cnt <= r_cnt + 1'b1;
                    r_a   <= w_a_mul;
                    r_esh <= r_esh << 1;
                end
                ADD: begin
                    r_s_out   <= mod_add(r_a, r_kr);
                    r_s_valid <= 1'b1;
                end
                DONE: begin
                    if (bus.s_ready) begin
                        r_s_valid <= 1'b0;
`ifdef SCHNORR_ZEROIZE_EN
                        r_key        <= '0;
                        r_key_loaded <= 1'b0;
`endif
                    end
                end
                default: r_cnt <= '0;
            endcase
        end
    end

    assign bus.ready   = (r_state == IDLE) && r_key_loaded;
    assign bus.busy    = (r_state != IDLE);
    assign bus.s_out   = r_s_out;
    assign bus.s_valid = r_s_valid;
endmodule

// File: tb/tb_schnorr_resp.sv
// Directed bench for schnorr_resp at len=8, q=251 with hand-computed responses.
module tb_schnorr_resp;
    localparam int         LEN = 8;
    localparam logic [7:0] Q   = 8'd251;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    schnorr_resp_if #(.len(LEN)) bus ();

    schnorr_resp #(.len(LEN), .q(Q)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    task automatic load_key(input logic [7:0] x);
        @(negedge clk);
        bus.key_valid = 1'b1;
        bus.priv_key  = x;
        @(negedge clk);
        bus.key_valid = 1'b0;
        bus.priv_key  = 8'h00;
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!bus.ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, " rdy"}, 32'(bus.ready), 32'd1);
    endtask

    // Accept, count edges to s_valid, check result, then hand off.
    task automatic run_op(input string tag, input logic [7:0] k, input logic [7:0] e,
                          input logic [7:0] exp_s, input bit disturb);
        int n;
        bit seen;
        wait_ready(tag);
        @(negedge clk);
        bus.start = 1'b1;
        bus.k_in  = k;
        bus.e_in  = e;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.k_in  = 8'h5A;
        bus.e_in  = 8'hA5;
        if (disturb) begin
            bus.key_valid = 1'b1;
            bus.priv_key  = 8'hC3;
        end
        seen = 1'b0;
        n = 0;
        while (!seen && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            seen = bus.s_valid;
        end
        bus.key_valid = 1'b0;
        check({tag, " lat"}, 32'(n), 32'd18);
        check({tag, " s"}, 32'(bus.s_out), 32'(exp_s));
        @(negedge clk);
        bus.s_ready = 1'b1;
        @(posedge clk);
        #1;
        check({tag, " sv_clr"}, 32'(bus.s_valid), 32'd0);
        bus.s_ready = 1'b0;
    endtask

    initial begin
        int  n;
        bit  bad;
        bus.key_valid = 1'b0;
        bus.priv_key  = '0;
        bus.start     = 1'b0;
        bus.k_in      = '0;
        bus.e_in      = '0;
        bus.s_ready   = 1'b0;

        repeat (3) @(negedge clk);
        check("rst ready", 32'(bus.ready), 32'd0);
        check("rst busy", 32'(bus.busy), 32'd0);
        check("rst s_valid", 32'(bus.s_valid), 32'd0);
        check("rst s_out", 32'(bus.s_out), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("nokey ready", 32'(bus.ready), 32'd0);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("nokey start ignored", 32'(bus.busy), 32'd0);

        load_key(8'd5);   run_op("x5k7e3", 8'd7, 8'd3, 8'd22, 1'b1);
        load_key(8'd250); run_op("x250k250e250", 8'd250, 8'd250, 8'd0, 1'b0);
        load_key(8'd255); run_op("x255k0e1", 8'd0, 8'd1, 8'd4, 1'b0);
        load_key(8'd9);   run_op("x9k255e0", 8'd255, 8'd0, 8'd4, 1'b0);

        // Backpressure: result must hold while s_ready is low, start pulses ignored.
        load_key(8'd5);
        wait_ready("hold");
        @(negedge clk);
        bus.start = 1'b1; bus.k_in = 8'd7; bus.e_in = 8'd3;
        @(negedge clk);
        bus.start = 1'b0;
        n = 0;
        while (!bus.s_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.start = i[0];
            bus.k_in  = 8'd1;
            bus.e_in  = 8'd1;
            @(posedge clk);
            #1;
            check("hold sv_s", {23'd0, bus.s_valid, bus.s_out}, {23'd0, 1'b1, 8'd22});
        end
        @(negedge clk);
        bus.start = 1'b0;
        bus.s_ready = 1'b1;
        @(negedge clk);
        bus.s_ready = 1'b0;
        check("hold release sv", 32'(bus.s_valid), 32'd0);
        check("hold release busy", 32'(bus.busy), 32'd0);

        // Reset during MUL aborts without a result.
        load_key(8'd5);
        wait_ready("abort");
        @(negedge clk);
        bus.start = 1'b1; bus.k_in = 8'd1; bus.e_in = 8'd2;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (12) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("abort s_out", 32'(bus.s_out), 32'd0);
        check("abort s_valid", 32'(bus.s_valid), 32'd0);
        check("abort busy", 32'(bus.busy), 32'd0);
        check("abort ready", 32'(bus.ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.s_valid || bus.ready || bus.busy) bad = 1'b1;
        end
        check("abort quiet", 32'(bad), 32'd0);
        load_key(8'd5);
        check("abort rekey ready", 32'(bus.ready), 32'd1);

`ifdef SCHNORR_ZEROIZE_EN
        run_op("zero first", 8'd7, 8'd3, 8'd22, 1'b0);
        repeat (3) @(negedge clk);
        check("zero ready", 32'(bus.ready), 32'd0);
`else
        run_op("keep first", 8'd7, 8'd3, 8'd22, 1'b0);
        run_op("keep second", 8'd1, 8'd10, 8'd51, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
